pf_lanectrl_dly_seq: RTL and testbench

Fabric-side sequencer for one PolarFire lane controller's TX DQS delay line. It accepts load/move commands from a requester over a valid/ready handshake. It drives the lane's DELAY_LINE_SEL/LOAD/DIRECTION/MOVE strobes with enforced spacing, brackets each operation with HS_IO_CLK_PAUSE, and tracks the current tap position. It sits between the lane-training logic and the LANECTRL wrapper in TX IOD components such as PF_IOD_LVDS_TX.

---
 rtl/pf_lanectrl_dly_seq.sv | 232 +++++++++++++++++++++++
 tb/tb_pf_lanectrl_dly_seq.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pf_lanectrl_dly_seq.sv
// rtl/pf_lanectrl_dly_seq.sv - TX DQS delay-line load/move sequencer for one PolarFire lane controller
// Optional feature macro: PF_LANECTRL_SEQ_PAUSE_EN (adds HS_IO_CLK_PAUSE bracketing via PRE/POST states)
module pf_lanectrl_dly_seq #(
    parameter int PAUSE_PRE  = 2,
    parameter int PAUSE_POST = 2,
    parameter int MOVE_GAP   = 4,
    parameter int LOAD_TAP   = 1,
    parameter int TAP_MAX    = 127
) (
    input  logic       FAB_CLK,
    input  logic       RESET,
    input  logic       CMD_VALID,
    output logic       CMD_READY,
    input  logic       CMD_OP,
    input  logic       CMD_DIR,
    input  logic [7:0] CMD_TAPS,
    output logic       DONE,
    output logic       ERR,
    output logic [7:0] TAP_POS,
    input  logic       TX_DELAY_LINE_OUT_OF_RANGE,
    output logic       DELAY_LINE_SEL,
    output logic       DELAY_LINE_LOAD,
    output logic       DELAY_LINE_DIRECTION,
    output logic       DELAY_LINE_MOVE,
    output logic       HS_IO_CLK_PAUSE
);

    // One shared down-counter times PRE, GAP and POST; size it for the longest of them.
    localparam int CNT_MAX_A = (PAUSE_PRE > PAUSE_POST) ? PAUSE_PRE : PAUSE_POST;
    localparam int CNT_MAX   = (CNT_MAX_A > MOVE_GAP) ? CNT_MAX_A : MOVE_GAP;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    localparam logic [7:0] LOAD_TAP_V = 8'(LOAD_TAP);
    localparam logic [7:0] TAP_MAX_V  = 8'(TAP_MAX);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_LOAD,
        ST_MOVE,
        ST_GAP,
        ST_POST,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       rem_q, rem_d;
    logic             op_q, op_d;
    logic             dir_q, dir_d;
    logic [7:0]       tap_q, tap_d;
    logic             err_q, err_d;

    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic             sel_q, sel_d;
    logic             load_q, load_d;
    logic             direction_q, direction_d;
    logic             move_q, move_d;
    logic             pause_q, pause_d;

    logic             start_op;
    logic             try_move;
    logic             finish;

    // Next-state: per-state timing first, then the shared "start op", "try a pulse" and "wrap up" steps.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        op_d     = op_q;
        dir_d    = dir_q;
        tap_d    = tap_q;
        err_d    = err_q;
        start_op = 1'b0;
        try_move = 1'b0;
        finish   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (CMD_VALID && ready_q) begin
                    op_d  = CMD_OP;
                    dir_d = CMD_DIR;
                    rem_d = CMD_TAPS;
                    err_d = 1'b0;
`ifdef PF_LANECTRL_SEQ_PAUSE_EN
                    state_d = ST_PRE;
                    cnt_d   = CNT_W'(PAUSE_PRE - 1);
`else
                    start_op = 1'b1;
`endif
                end
            end
            ST_PRE: begin
                if (cnt_q == '0) begin
                    start_op = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_LOAD: begin
                finish = 1'b1;
            end
            ST_MOVE: begin
                state_d = ST_GAP;
                cnt_d   = CNT_W'(MOVE_GAP - 2);
            end
            ST_GAP: begin
                // A range fault reported during spacing abandons the remaining taps.
                if (TX_DELAY_LINE_OUT_OF_RANGE) begin
                    err_d  = 1'b1;
                    finish = 1'b1;
                end else if (cnt_q == '0) begin
                    if (rem_q != 8'd0) begin
                        try_move = 1'b1;
                    end else begin
                        finish = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_POST: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (start_op) begin
            if (!op_d) begin
                state_d = ST_LOAD;
                tap_d   = LOAD_TAP_V;
            end else if (rem_d != 8'd0) begin
                try_move = 1'b1;
            end else begin
                finish = 1'b1;
            end
        end

        // Bound check happens before entering MOVE, so an out-of-range step never pulses.
        if (try_move) begin
            if ((dir_d && (tap_q == TAP_MAX_V)) || (!dir_d && (tap_q == 8'd0))) begin
                err_d  = 1'b1;
                finish = 1'b1;
            end else begin
                state_d = ST_MOVE;
                tap_d   = dir_d ? (tap_q + 8'd1) : (tap_q - 8'd1);
                rem_d   = rem_d - 8'd1;
            end
        end

        if (finish) begin
`ifdef PF_LANECTRL_SEQ_PAUSE_EN
            state_d = ST_POST;
            cnt_d   = CNT_W'(PAUSE_POST - 1);
`else
            state_d = ST_DONE;
`endif
        end
    end

    // Output decode from the next state so every strobe leaves a flop aligned with its state.
    always_comb begin
        ready_d     = (state_d == ST_IDLE);
        done_d      = (state_d == ST_DONE);
        load_d      = (state_d == ST_LOAD);
        move_d      = (state_d == ST_MOVE);
        sel_d       = load_d || move_d;
        direction_d = ((state_d != ST_IDLE) && (state_d != ST_DONE)) ? dir_d : 1'b0;
`ifdef PF_LANECTRL_SEQ_PAUSE_EN
        pause_d     = (state_d == ST_PRE) || (state_d == ST_LOAD) || (state_d == ST_MOVE) ||
                      (state_d == ST_GAP) || (state_d == ST_POST);
`else
        pause_d     = 1'b0;
`endif
    end

    // State, bookkeeping and registered outputs; reset drops any strobe in flight.
    always_ff @(posedge FAB_CLK) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rem_q       <= 8'd0;
            op_q        <= 1'b0;
            dir_q       <= 1'b0;
            tap_q       <= LOAD_TAP_V;
            err_q       <= 1'b0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            sel_q       <= 1'b0;
            load_q      <= 1'b0;
            direction_q <= 1'b0;
            move_q      <= 1'b0;
            pause_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            op_q        <= op_d;
            dir_q       <= dir_d;
            tap_q       <= tap_d;
            err_q       <= err_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            sel_q       <= sel_d;
            load_q      <= load_d;
            direction_q <= direction_d;
            move_q      <= move_d;
            pause_q     <= pause_d;
        end
    end

    assign CMD_READY            = ready_q;
    assign DONE                 = done_q;
    assign ERR                  = err_q;
    assign TAP_POS              = tap_q;
    assign DELAY_LINE_SEL       = sel_q;
    assign DELAY_LINE_LOAD      = load_q;
    assign DELAY_LINE_DIRECTION = direction_q;
    assign DELAY_LINE_MOVE      = move_q;
    assign HS_IO_CLK_PAUSE      = pause_q;

endmodule

// File: tb/tb_pf_lanectrl_dly_seq.sv
// tb/tb_pf_lanectrl_dly_seq.sv - self-checking bench for pf_lanectrl_dly_seq
module tb_pf_lanectrl_dly_seq;

`ifdef PF_LANECTRL_SEQ_PAUSE_EN
    localparam int PRE  = 2;
    localparam int POST = 2;
    localparam bit PEN  = 1'b1;
`else
    localparam int PRE  = 0;
    localparam int POST = 0;
    localparam bit PEN  = 1'b0;
`endif
    localparam int G        = 4;
    localparam int LOAD_TAP = 1;
    localparam int TAP_MAX  = 127;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_op;
    logic       cmd_dir;
    logic [7:0] cmd_taps;
    logic       done;
    logic       err;
    logic [7:0] tap_pos;
    logic       oor;
    logic       dl_sel, dl_load, dl_dir, dl_move, pause;

    int total = 0;
    int bad   = 0;
    int model_tap;

    pf_lanectrl_dly_seq #(
        .PAUSE_PRE(2), .PAUSE_POST(2), .MOVE_GAP(G), .LOAD_TAP(LOAD_TAP), .TAP_MAX(TAP_MAX)
    ) dut (
        .FAB_CLK(clk),
        .RESET(rst),
        .CMD_VALID(cmd_valid),
        .CMD_READY(cmd_ready),
        .CMD_OP(cmd_op),
        .CMD_DIR(cmd_dir),
        .CMD_TAPS(cmd_taps),
        .DONE(done),
        .ERR(err),
        .TAP_POS(tap_pos),
        .TX_DELAY_LINE_OUT_OF_RANGE(oor),
        .DELAY_LINE_SEL(dl_sel),
        .DELAY_LINE_LOAD(dl_load),
        .DELAY_LINE_DIRECTION(dl_dir),
        .DELAY_LINE_MOVE(dl_move),
        .HS_IO_CLK_PAUSE(pause)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit op;
        bit dir;
        int taps;
        int oor_k;
        int exp_done;
        int exp_tap;
        bit exp_err;
    } vec_t;

    vec_t tbl[12];

    // bits: 15 ready, 14 done, 13 sel, 12 load, 11 dir, 10 move, 9 pause, 8 err, 7:0 tap
    function automatic logic [15:0] obs();
        return {cmd_ready, done, dl_sel, dl_load, dl_dir, dl_move, pause, err, tap_pos};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_vec(input string name, input int c, input logic [15:0] act,
                             input logic [15:0] exp, input logic [15:0] mask);
        total++;
        if ((act & mask) !== (exp & mask)) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%b want=%b", name, c, act & mask, exp & mask);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    // Outcome of one command from the rules: pulses taken, completion cycle, final tap, error.
    task automatic model(input bit op, input bit dir, input int n, input int start, input int oor_k,
                         output int p, output int done_c, output int fin_tap, output bit e,
                         output int oor_c);
        if (!op) begin
            p = 0; done_c = PRE + POST + 2; fin_tap = LOAD_TAP; e = 1'b0; oor_c = -1;
        end else begin
            int room;
            room = dir ? (TAP_MAX - start) : start;
            p = (n < room) ? n : room;
            if (oor_k >= 0 && oor_k < p) begin
                p = oor_k + 1;
                e = 1'b1;
                oor_c = PRE + 2 + oor_k * G;
                done_c = oor_c + POST + 1;
            end else begin
                oor_c = -1;
                e = (p < n);
                done_c = PRE + p * G + POST + 1;
            end
            fin_tap = dir ? (start + p) : (start - p);
        end
    endtask

    task automatic run_cmd(input bit op, input bit dir, input int taps, input int oor_k,
                           input bit noisy, output int act_done, output int act_tap,
                           output bit act_err);
        int p, done_c, fin_tap, oor_c, gap_end, tap_c, k;
        bit e, pulse, ld, in_gap;
        logic [15:0] ex, mask;
        model(op, dir, taps, model_tap, oor_k, p, done_c, fin_tap, e, oor_c);
        gap_end = (oor_c >= 0) ? oor_c : PRE + p * G;
        cmd_valid = 1'b1; cmd_op = op; cmd_dir = dir; cmd_taps = 8'(taps);
        act_done = -1;
        for (int c = 1; c <= done_c; c++) begin
            step();
            in_gap = op && (c > PRE + 1) && (c <= gap_end) && (((c - PRE - 1) % G) != 0);
            if (noisy) begin
                cmd_valid = 1'($urandom_range(0, 1));
                cmd_op    = 1'($urandom_range(0, 1));
                cmd_dir   = 1'($urandom_range(0, 1));
                cmd_taps  = 8'($urandom_range(0, 255));
                oor       = (c == oor_c) || (!in_gap && ($urandom_range(0, 3) == 0));
            end else begin
                cmd_valid = 1'b0;
                oor       = (c == oor_c);
            end
            k     = (c >= PRE + 1) ? ((c - PRE - 1) / G) : 0;
            pulse = op && (c >= PRE + 1) && (((c - PRE - 1) % G) == 0) && (k < p);
            ld    = !op && (c == PRE + 1);
            if (!op) tap_c = (c >= PRE + 1) ? LOAD_TAP : model_tap;
            else begin
                int taken;
                taken = (c >= PRE + 1) ? (((k + 1) < p) ? (k + 1) : p) : 0;
                tap_c = dir ? (model_tap + taken) : (model_tap - taken);
            end
            ex = {1'b0, (c == done_c), pulse | ld, ld, (c < done_c) ? dir : 1'b0, pulse,
                  PEN && (c < done_c), e && (c >= done_c - POST), 8'(tap_c)};
            mask = 16'hFFFF;
            if (c == done_c) mask[11] = 1'b0;
            check_vec("cmd", c, obs(), ex, mask);
            if (done && act_done < 0) act_done = c;
        end
        step();
        cmd_valid = 1'b0;
        oor = 1'b0;
        check_vec("idle_after", done_c + 1, obs(), {8'b1000_0000 | {7'd0, e}, 8'(fin_tap)}, 16'hFFFF);
        act_tap = tap_pos;
        act_err = err;
        model_tap = fin_tap;
    endtask

    initial begin
        int ad, at, wc;
        bit ae;

        tbl[0]  = '{1'b0, 1'b0, 0,   -1, PRE + POST + 2,           1,   1'b0};
        tbl[1]  = '{1'b1, 1'b1, 3,   -1, PRE + 3 * G + POST + 1,   4,   1'b0};
        tbl[2]  = '{1'b1, 1'b0, 2,   -1, PRE + 2 * G + POST + 1,   2,   1'b0};
        tbl[3]  = '{1'b1, 1'b0, 5,   -1, PRE + 2 * G + POST + 1,   0,   1'b1};
        tbl[4]  = '{1'b0, 1'b1, 0,   -1, PRE + POST + 2,           1,   1'b0};
        tbl[5]  = '{1'b1, 1'b1, 4,    0, PRE + POST + 3,           2,   1'b1};
        tbl[6]  = '{1'b1, 1'b1, 0,   -1, PRE + POST + 1,           2,   1'b0};
        tbl[7]  = '{1'b1, 1'b1, 125, -1, PRE + 125 * G + POST + 1, 127, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 1,   -1, PRE + POST + 1,           127, 1'b1};
        tbl[9]  = '{1'b1, 1'b0, 1,    0, PRE + POST + 3,           126, 1'b1};
        tbl[10] = '{1'b1, 1'b0, 3,    2, PRE + 2 * G + POST + 3,   123, 1'b1};
        tbl[11] = '{1'b0, 1'b0, 0,   -1, PRE + POST + 2,           1,   1'b0};

        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_dir = 1'b0; cmd_taps = 8'd0; oor = 1'b0;
        repeat (3) step();
        check_vec("reset", 0, obs(), {8'b1000_0000, 8'(LOAD_TAP)}, 16'hFFFF);
        rst = 1'b0;
        step();
        check_vec("reset_release", 0, obs(), {8'b1000_0000, 8'(LOAD_TAP)}, 16'hFFFF);
        model_tap = LOAD_TAP;

        for (int i = 0; i < 12; i++) begin
            run_cmd(tbl[i].op, tbl[i].dir, tbl[i].taps, tbl[i].oor_k, 1'b0, ad, at, ae);
            check_int($sformatf("tbl%0d_done", i), ad, tbl[i].exp_done);
            check_int($sformatf("tbl%0d_tap", i), at, tbl[i].exp_tap);
            check_int($sformatf("tbl%0d_err", i), int'(ae), int'(tbl[i].exp_err));
        end

        for (int i = 0; i < 40; i++) begin
            bit rop, rdir;
            int rtaps, rk;
            rop   = ($urandom_range(0, 5) != 0);
            rdir  = 1'($urandom_range(0, 1));
            rtaps = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 60)) : int'($urandom_range(0, 6));
            rk    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
            run_cmd(rop, rdir, rtaps, rk, 1'b1, ad, at, ae);
        end

        // Reset in the middle of a MOVE, with CMD_VALID held across reset.
        cmd_valid = 1'b1; cmd_op = 1'b1; cmd_dir = 1'b1; cmd_taps = 8'd5;
        repeat (8) step();
        check_int("mid_move_busy", int'(cmd_ready), 0);
        rst = 1'b1;
        step();
        check_vec("mid_reset", 9, obs(), {8'b1000_0000, 8'(LOAD_TAP)}, 16'hFFFF);
        rst = 1'b0;
        step();
        check_int("accept_after_reset", int'(cmd_ready), 0);
        cmd_valid = 1'b0;
        wc = 1;
        while (!done && wc < 200) begin
            step();
            wc++;
        end
        check_int("post_reset_done", done ? wc : -1, PRE + 5 * G + POST + 1);
        step();
        check_vec("post_reset_idle", 0, obs(), {8'b1000_0000, 8'(LOAD_TAP + 5)}, 16'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
